mem_req_arb: RTL and testbench

- Arbiter and sequencer in front of the byte-serial memory controller.
- Shares the single RAM channel between three requesters: store-commit (from ROB), load (from SLB) and instruction line fetch (from icache).
- Fixed priority is store > load > fetch, with a starvation counter that guarantees fetch progress.
- Handles rollback cancellation of in-flight loads, and routes the controller's completion pulse and read data back to the owning requester.

---
 rtl/mem_req_arb_if.sv | 57 +++++
 rtl/mem_req_arb.sv | 178 +++++++++++++++++
 tb/tb_mem_req_arb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arb_if.sv
// Bundle of requester, rollback and memory-controller signals around mem_req_arb.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_req_arb_if;
    logic         rdy;
    logic         rb;

    logic         fc_valid;
    logic [31:0]  fc_addr;
    logic         fc_done;
    logic [127:0] fc_line;

    logic         ld_valid;
    logic [31:0]  ld_addr;
    logic [3:0]   ld_len;
    logic         ld_io_ok;
    logic         ld_done;
    logic [31:0]  ld_data;

    logic         st_valid;
    logic [31:0]  st_addr;
    logic [31:0]  st_data;
    logic [3:0]   st_len;
    logic         st_done;

    logic         mc_req_valid;
    logic [1:0]   mc_req_kind;
    logic [31:0]  mc_req_addr;
    logic [31:0]  mc_req_wdata;
    logic [3:0]   mc_req_len;
    logic         mc_req_abort;
    logic         mc_req_done;
    logic [127:0] mc_req_rdata;

    modport slave (
        input  rdy, rb,
        input  fc_valid, fc_addr,
        output fc_done, fc_line,
        input  ld_valid, ld_addr, ld_len, ld_io_ok,
        output ld_done, ld_data,
        input  st_valid, st_addr, st_data, st_len,
        output st_done,
        output mc_req_valid, mc_req_kind, mc_req_addr, mc_req_wdata, mc_req_len, mc_req_abort,
        input  mc_req_done, mc_req_rdata
    );

    modport master (
        output rdy, rb,
        output fc_valid, fc_addr,
        input  fc_done, fc_line,
        output ld_valid, ld_addr, ld_len, ld_io_ok,
        input  ld_done, ld_data,
        output st_valid, st_addr, st_data, st_len,
        input  st_done,
        input  mc_req_valid, mc_req_kind, mc_req_addr, mc_req_wdata, mc_req_len, mc_req_abort,
        output mc_req_done, mc_req_rdata
    );
endinterface

// File: rtl/mem_req_arb.sv
// Store > load > fetch arbiter for the single RAM channel, with fetch starvation guard
// and load rollback abort. Optional macro ARB_IO_GUARD_EN holds IO loads until ld_io_ok.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no request outstanding; arbitrate and latch the winner
// S_BUSY  | request held to the controller until mc_req_done or load rollback
// S_ABORT | one cycle after a load abort; controller done is ignored
module mem_req_arb #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_req_arb_if.slave  bus
);

    localparam logic [1:0]       KIND_FC   = 2'd0;
    localparam logic [1:0]       KIND_LD   = 2'd1;
    localparam logic [1:0]       KIND_ST   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ABORT
    } state_t;

    state_t         r_state;
    logic [CNT_W-1:0] r_starve_cnt;

    logic           r_fc_done;
    logic [127:0]   r_fc_line;
    logic           r_ld_done;
    logic [31:0]    r_ld_data;
    logic           r_st_done;
    logic           r_mc_valid;
    logic [1:0]     r_mc_kind;
    logic [31:0]    r_mc_addr;
    logic [31:0]    r_mc_wdata;
    logic [3:0]     r_mc_len;
    logic           r_mc_abort;

    logic           w_fc_elig;
    logic           w_ld_elig;
    logic           w_st_elig;
    logic           w_force_fc;
    logic           w_gnt;
    logic [1:0]     w_gnt_kind;

    // A requester whose done is showing this cycle has not yet dropped valid.
    assign w_fc_elig = bus.fc_valid && !r_fc_done;
    assign w_st_elig = bus.st_valid && !r_st_done;

`ifdef ARB_IO_GUARD_EN
    logic w_ld_is_io;
    assign w_ld_is_io = (bus.ld_addr[17:16] == 2'b11);
    assign w_ld_elig  = bus.ld_valid && !r_ld_done && !bus.rb && (!w_ld_is_io || bus.ld_io_ok);
`else
    assign w_ld_elig  = bus.ld_valid && !r_ld_done && !bus.rb;
`endif

    assign w_force_fc = (r_starve_cnt >= CNT_LIMIT) && w_fc_elig;

    always_comb begin
        w_gnt      = 1'b0;
        w_gnt_kind = KIND_FC;
        if (w_force_fc) begin
            w_gnt      = 1'b1;
            w_gnt_kind = KIND_FC;
        end else if (w_st_elig) begin
            w_gnt      = 1'b1;
            w_gnt_kind = KIND_ST;
        end else if (w_ld_elig) begin
            w_gnt      = 1'b1;
            w_gnt_kind = KIND_LD;
        end else if (w_fc_elig) begin
            w_gnt      = 1'b1;
            w_gnt_kind = KIND_FC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_fc_done    <= 1'b0;
            r_fc_line    <= '0;
            r_ld_done    <= 1'b0;
            r_ld_data    <= '0;
            r_st_done    <= 1'b0;
            r_mc_valid   <= 1'b0;
            r_mc_kind    <= KIND_FC;
            r_mc_addr    <= '0;
            r_mc_wdata   <= '0;
            r_mc_len     <= '0;
            r_mc_abort   <= 1'b0;
        end else if (bus.rdy) begin
            r_fc_done  <= 1'b0;
            r_ld_done  <= 1'b0;
            r_st_done  <= 1'b0;
            r_mc_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt) begin
                        r_mc_valid <= 1'b1;
                        r_mc_kind  <= w_gnt_kind;
                        r_state    <= S_BUSY;
                        case (w_gnt_kind)
                            KIND_ST: begin
                                r_mc_addr  <= bus.st_addr;
                                r_mc_wdata <= bus.st_data;
                                r_mc_len   <= bus.st_len;
                            end
                            KIND_LD: begin
                                r_mc_addr  <= bus.ld_addr;
                                r_mc_wdata <= '0;
                                r_mc_len   <= bus.ld_len;
                            end
                            default: begin
                                r_mc_addr  <= bus.fc_addr;
                                r_mc_wdata <= '0;
                                r_mc_len   <= 4'hF;
                            end
                        endcase
                        if (w_gnt_kind == KIND_FC) begin
                            r_starve_cnt <= '0;
                        end else if (bus.fc_valid && (r_starve_cnt != CNT_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    // Rollback wins over a coincident controller done for loads.
                    if (bus.rb && (r_mc_kind == KIND_LD)) begin
                        r_mc_valid <= 1'b0;
                        r_mc_abort <= 1'b1;
                        r_state    <= S_ABORT;
                    end else if (bus.mc_req_done) begin
                        r_mc_valid <= 1'b0;
                        r_state    <= S_IDLE;
                        case (r_mc_kind)
                            KIND_ST: r_st_done <= 1'b1;
                            KIND_LD: begin
                                r_ld_done <= 1'b1;
                                r_ld_data <= bus.mc_req_rdata[31:0];
                            end
                            default: begin
                                r_fc_done <= 1'b1;
                                r_fc_line <= bus.mc_req_rdata;
                            end
                        endcase
                    end
                end
                S_ABORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fc_done      = r_fc_done;
    assign bus.fc_line      = r_fc_line;
    assign bus.ld_done      = r_ld_done;
    assign bus.ld_data      = r_ld_data;
    assign bus.st_done      = r_st_done;
    assign bus.mc_req_valid = r_mc_valid;
    assign bus.mc_req_kind  = r_mc_kind;
    assign bus.mc_req_addr  = r_mc_addr;
    assign bus.mc_req_wdata = r_mc_wdata;
    assign bus.mc_req_len   = r_mc_len;
    assign bus.mc_req_abort = r_mc_abort;

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb: inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_mem_req_arb;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    mem_req_arb_if bus ();

    mem_req_arb #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_valid(input string tag, output logic [1:0] kind);
        int n;
        n = 0;
        while (!bus.mc_req_valid && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_grant_seen"}, 128'(bus.mc_req_valid), 128'd1);
        kind = bus.mc_req_kind;
    endtask

    task automatic complete(input int nwait, input logic [127:0] data);
        repeat (nwait) tick();
        bus.mc_req_done  = 1'b1;
        bus.mc_req_rdata = data;
        tick();
        bus.mc_req_done  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] kind;
        logic [1:0] exp_kind;

        rst = 1'b1;
        bus.rdy = 1'b1;      bus.rb = 1'b0;
        bus.fc_valid = 1'b0; bus.fc_addr = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_len = '0; bus.ld_io_ok = 1'b0;
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_len = '0;
        bus.mc_req_done = 1'b0; bus.mc_req_rdata = '0;
        tick(); tick();

        chk("rst_valid", 128'(bus.mc_req_valid), 128'd0);
        chk("rst_kind",  128'(bus.mc_req_kind),  128'd0);
        chk("rst_addr",  128'(bus.mc_req_addr),  128'd0);
        chk("rst_len",   128'(bus.mc_req_len),   128'd0);
        chk("rst_dones", 128'({bus.fc_done, bus.ld_done, bus.st_done, bus.mc_req_abort}), 128'd0);
        chk("rst_line",  bus.fc_line, 128'd0);
        rst = 1'b0;

        // single fetch, plus pulse freeze under rdy=0
        bus.fc_valid = 1'b1; bus.fc_addr = 32'h0000_1000;
        tick();
        chk("fc_valid_up", 128'(bus.mc_req_valid), 128'd1);
        chk("fc_kind",     128'(bus.mc_req_kind),  128'd0);
        chk("fc_len",      128'(bus.mc_req_len),   128'd15);
        chk("fc_addr",     128'(bus.mc_req_addr),  128'h1000);
        complete(1, 128'h0123456789ABCDEF0123456789ABCDEF);
        bus.fc_valid = 1'b0;
        chk("fc_done",     128'(bus.fc_done),      128'd1);
        chk("fc_line",     bus.fc_line,            128'h0123456789ABCDEF0123456789ABCDEF);
        chk("fc_valid_dn", 128'(bus.mc_req_valid), 128'd0);
        bus.rdy = 1'b0;
        tick();
        chk("rdy_hold_pulse", 128'(bus.fc_done), 128'd1);
        bus.rdy = 1'b1;
        tick();
        chk("fc_done_once", 128'(bus.fc_done), 128'd0);

        // store and load together
        bus.st_valid = 1'b1; bus.st_addr = 32'h100; bus.st_len = 4'd3; bus.st_data = 32'hDEADBEEF;
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h200; bus.ld_len = 4'd1;
        tick();
        chk("st_kind",  128'(bus.mc_req_kind),  128'd2);
        chk("st_addr",  128'(bus.mc_req_addr),  128'h100);
        chk("st_wdata", 128'(bus.mc_req_wdata), 128'hDEADBEEF);
        chk("st_len",   128'(bus.mc_req_len),   128'd3);
        complete(0, 128'd0);
        bus.st_valid = 1'b0;
        chk("st_done",    128'(bus.st_done),      128'd1);
        chk("ld_bubble",  128'(bus.mc_req_valid), 128'd0);
        tick();
        chk("ld_valid_up", 128'(bus.mc_req_valid), 128'd1);
        chk("ld_kind",     128'(bus.mc_req_kind),  128'd1);
        chk("ld_len",      128'(bus.mc_req_len),   128'd1);
        chk("ld_addr",     128'(bus.mc_req_addr),  128'h200);
        complete(0, 128'h11111111_22222222_33333333_CAFEF00D);
        bus.ld_valid = 1'b0;
        chk("ld_done", 128'(bus.ld_done), 128'd1);
        chk("ld_data", 128'(bus.ld_data), 128'hCAFEF00D);
        tick();

        // starvation: all three held valid, loads/stores alternate until fetch is forced
        bus.fc_valid = 1'b1; bus.ld_valid = 1'b1; bus.st_valid = 1'b1;
        for (int g = 0; g < 10; g++) begin
            wait_valid("starve", kind);
            if (g < 8) exp_kind = (g % 2 == 0) ? 2'd2 : 2'd1;
            else if (g == 8) exp_kind = 2'd0;
            else exp_kind = 2'd2;
            chk($sformatf("starve_kind_%0d", g), 128'(kind), 128'(exp_kind));
            if (g == 7) chk("starve_cnt_sat", 128'(dut.r_starve_cnt), 128'd8);
            if (g == 8) chk("starve_cnt_clr", 128'(dut.r_starve_cnt), 128'd0);
            complete(2, 128'd0);
        end
        bus.fc_valid = 1'b0; bus.ld_valid = 1'b0; bus.st_valid = 1'b0;
        tick(); tick();

        // rollback of an in-flight load with coincident controller done
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h400; bus.ld_len = 4'd0;
        tick();
        chk("rb_ld_kind", 128'(bus.mc_req_kind), 128'd1);
        bus.st_valid = 1'b1; bus.st_addr = 32'h500; bus.st_len = 4'd0; bus.st_data = 32'hA5;
        tick();
        bus.rb = 1'b1; bus.mc_req_done = 1'b1; bus.mc_req_rdata = 128'hFFFF;
        tick();
        bus.rb = 1'b0; bus.mc_req_done = 1'b0; bus.ld_valid = 1'b0;
        chk("rb_abort",    128'(bus.mc_req_abort), 128'd1);
        chk("rb_valid_dn", 128'(bus.mc_req_valid), 128'd0);
        chk("rb_no_ld",    128'(bus.ld_done),      128'd0);
        tick();
        chk("rb_abort_once", 128'(bus.mc_req_abort), 128'd0);
        chk("rb_no_ld2",     128'(bus.ld_done),      128'd0);
        chk("rb_gap",        128'(bus.mc_req_valid), 128'd0);
        tick();
        chk("rb_st_grant", 128'({bus.mc_req_valid, bus.mc_req_kind}), 128'h6);
        complete(0, 128'd0);
        bus.st_valid = 1'b0;
        chk("rb_st_done", 128'(bus.st_done), 128'd1);
        tick();

        // reset in the middle of a store
        bus.st_valid = 1'b1; bus.st_addr = 32'h300; bus.st_len = 4'd3; bus.st_data = 32'h11223344;
        tick();
        chk("rstb_st_up", 128'({bus.mc_req_valid, bus.mc_req_kind}), 128'h6);
        rst = 1'b1; bus.mc_req_done = 1'b1;
        tick();
        rst = 1'b0; bus.mc_req_done = 1'b0; bus.st_valid = 1'b0;
        chk("rstb_clear", 128'({bus.mc_req_valid, bus.mc_req_kind, bus.mc_req_addr, bus.mc_req_wdata, bus.mc_req_len}), 128'd0);
        chk("rstb_no_st", 128'(bus.st_done), 128'd0);
        tick();
        chk("rstb_no_st2", 128'(bus.st_done), 128'd0);
        bus.fc_valid = 1'b1; bus.fc_addr = 32'h2000;
        tick();
        chk("rstb_fc_grant", 128'({bus.mc_req_valid, bus.mc_req_kind, bus.mc_req_len}), 128'h4F);
        chk("rstb_fc_addr",  128'(bus.mc_req_addr), 128'h2000);
        complete(0, 128'h5A);
        bus.fc_valid = 1'b0;
        chk("rstb_fc_done", 128'(bus.fc_done), 128'd1);
        tick();

        // IO load contending with fetch
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h0003_0000; bus.ld_len = 4'd3; bus.ld_io_ok = 1'b0;
        bus.fc_valid = 1'b1; bus.fc_addr = 32'h3000;
        tick();
`ifdef ARB_IO_GUARD_EN
        chk("io_fc_first", 128'(bus.mc_req_kind), 128'd0);
        complete(0, 128'd0);
        bus.fc_valid = 1'b0;
        tick();
        chk("io_ld_blocked", 128'(bus.mc_req_valid), 128'd0);
        tick();
        chk("io_ld_blocked2", 128'(bus.mc_req_valid), 128'd0);
        bus.ld_io_ok = 1'b1;
        tick();
        chk("io_ld_grant", 128'({bus.mc_req_valid, bus.mc_req_kind}), 128'h5);
        chk("io_ld_addr",  128'(bus.mc_req_addr), 128'h30000);
        complete(0, 128'h77);
        bus.ld_valid = 1'b0;
        chk("io_ld_done", 128'(bus.ld_done), 128'd1);
`else
        chk("io_ld_first", 128'(bus.mc_req_kind), 128'd1);
        chk("io_ld_addr",  128'(bus.mc_req_addr), 128'h30000);
        complete(0, 128'h77);
        bus.ld_valid = 1'b0;
        chk("io_ld_done", 128'(bus.ld_done), 128'd1);
        tick();
        chk("io_fc_next", 128'({bus.mc_req_valid, bus.mc_req_kind}), 128'h4);
        complete(0, 128'd0);
        bus.fc_valid = 1'b0;
        chk("io_fc_done", 128'(bus.fc_done), 128'd1);
`endif
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
